// File: rtl/render_scheduler.sv
// render_scheduler: hands pixels to whichever renderer is free, arbitrates
// the framebuffer write port round-robin, and flags frame completion.
module render_scheduler #(
  parameter int RENDER_COUNT = 4,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8,
  parameter int ITER_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic abort,
  output logic busy,
  output logic frame_done,
  output logic [RENDER_COUNT-1:0] r_start,
  output logic [RENDER_COUNT*X_BITS-1:0] r_x,
  output logic [RENDER_COUNT*Y_BITS-1:0] r_y,
  input  logic [RENDER_COUNT-1:0] r_done,
  input  logic [RENDER_COUNT*ITER_W-1:0] r_iters,
  output logic fb_we,
  output logic [X_BITS+Y_BITS-1:0] fb_addr,
  output logic [15:0] fb_data
);

  localparam int AW = X_BITS + Y_BITS;
  localparam int CW = AW + 1;
  localparam int RW = (RENDER_COUNT > 1) ? $clog2(RENDER_COUNT) : 1;
  localparam logic [CW-1:0] TOTAL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SL_FREE, SL_BUSY, SL_PEND
  } slot_t;

  state_t state_q, state_d;
  slot_t slot_q [RENDER_COUNT];
  logic [ITER_W-1:0] iters_q [RENDER_COUNT];
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] ptr_q;

  logic disp_ok, grant_ok, all_free;
  logic [RW-1:0] disp_idx, grant_idx, ptr_nxt;
  logic disp_en, grant_en, cap_en, start_en;
  logic [7:0] wr_lo;
  int j;

  always_comb begin
    disp_ok = 1'b0;
    disp_idx = '0;
    all_free = 1'b1;
    for (int i = RENDER_COUNT-1; i >= 0; i--) begin
      if (slot_q[i] == SL_FREE) begin
        disp_ok = 1'b1;
        disp_idx = RW'(i);
      end else begin
        all_free = 1'b0;
      end
    end
  end

  // first PEND slot at or after the round-robin pointer
  always_comb begin
    grant_ok = 1'b0;
    grant_idx = '0;
    j = 0;
    for (int k = RENDER_COUNT-1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= RENDER_COUNT) j = j - RENDER_COUNT;
      if (slot_q[RW'(j)] == SL_PEND) begin
        grant_ok = 1'b1;
        grant_idx = RW'(j);
      end
    end
  end

  always_comb begin
    ptr_nxt = grant_idx + RW'(1);
    if (int'(grant_idx) == RENDER_COUNT-1) ptr_nxt = '0;
    wr_lo = 8'(iters_q[grant_idx]) + 8'd16;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (cnt_q == TOTAL) state_d = S_DRAIN;
      S_DRAIN: if (all_free) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    start_en = (state_q == S_IDLE) && go;
    cap_en = (state_q == S_RUN) || (state_q == S_DRAIN);
    grant_en = cap_en && grant_ok;
    disp_en = (state_q == S_RUN) && (cnt_q != TOTAL) && disp_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      frame_done <= 1'b0;
      r_start <= '0;
      r_x <= '0;
      r_y <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < RENDER_COUNT; i++) begin
        slot_q[i] <= SL_FREE;
        iters_q[i] <= '0;
      end
    end else if (abort) begin
      busy <= 1'b0;
      frame_done <= 1'b0;
      r_start <= '0;
      r_x <= '0;
      r_y <= '0;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < RENDER_COUNT; i++) begin
        slot_q[i] <= SL_FREE;
        iters_q[i] <= '0;
      end
    end else begin
      r_start <= '0;
      fb_we <= 1'b0;
      frame_done <= (state_q == S_DRAIN) && all_free;
      if (state_q == S_DONE) busy <= 1'b0;
      if (start_en) begin
        busy <= 1'b1;
        cnt_q <= '0;
        ptr_q <= '0;
        for (int i = 0; i < RENDER_COUNT; i++) slot_q[i] <= SL_FREE;
      end
      if (cap_en) begin
        for (int i = 0; i < RENDER_COUNT; i++) begin
          if (r_done[i] && slot_q[i] == SL_BUSY) begin
            slot_q[i] <= SL_PEND;
            iters_q[i] <= r_iters[i*ITER_W +: ITER_W];
          end
        end
      end
      // capture, grant and dispatch touch disjoint slot states
      if (grant_en) begin
        slot_q[grant_idx] <= SL_FREE;
        fb_we <= 1'b1;
        fb_addr <= {r_y[grant_idx*Y_BITS +: Y_BITS],
                    r_x[grant_idx*X_BITS +: X_BITS]};
        fb_data <= {8'd128, wr_lo};
        ptr_q <= ptr_nxt;
      end
      if (disp_en) begin
        slot_q[disp_idx] <= SL_BUSY;
        r_start[disp_idx] <= 1'b1;
        r_x[disp_idx*X_BITS +: X_BITS] <= cnt_q[X_BITS-1:0];
        r_y[disp_idx*Y_BITS +: Y_BITS] <= cnt_q[AW-1:X_BITS];
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: random-latency renderer models plus a pixel-level
// reference of what each framebuffer address must receive.
module tb_render_scheduler;

  localparam int R = 4;
  localparam int XB = 4;
  localparam int YB = 3;
  localparam int IW = 8;
  localparam int NPIX = 1 << (XB + YB);

  logic clk = 1'b0;
  logic rst_n, go, abort;
  logic busy, frame_done, fb_we;
  logic [R-1:0] r_start, r_done;
  logic [R*XB-1:0] r_x;
  logic [R*YB-1:0] r_y;
  logic [R*IW-1:0] r_iters;
  logic [XB+YB-1:0] fb_addr;
  logic [15:0] fb_data;

  always #5 clk = ~clk;

  render_scheduler #(
    .RENDER_COUNT(R), .X_BITS(XB), .Y_BITS(YB), .ITER_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .busy(busy), .frame_done(frame_done),
    .r_start(r_start), .r_x(r_x), .r_y(r_y),
    .r_done(r_done), .r_iters(r_iters),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  int n_chk, n_fail, cyc;
  bit mbusy [R];
  bit mpend [R];
  int maddr [R];
  int rem [R];
  int lat [R];
  bit auto_mode;
  int exp_data [NPIX];
  bit written [NPIX];
  int next_disp, nwrites, nfd, last_wr, fd_cyc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, frame_done, r_start, r_x, r_y,
                fb_we, fb_addr, fb_data});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < R; i++) begin
      mbusy[i] = 0;
      mpend[i] = 0;
      rem[i] = 0;
    end
  endtask

  task automatic frame_clear();
    model_clear();
    next_disp = 0;
    nwrites = 0;
    nfd = 0;
    last_wr = -1;
    fd_cyc = -1;
    for (int a = 0; a < NPIX; a++) begin
      exp_data[a] = -1;
      written[a] = 0;
    end
  endtask

  // one cycle: account for the edge just passed, then drive the next one
  task automatic tick();
    int a;
    bit found;
    logic [7:0] lo;
    @(negedge clk);
    cyc++;
    if (!rst_n || abort) begin
      model_clear();
    end else begin
      for (int i = 0; i < R; i++) begin
        if (r_done[i] && mbusy[i]) begin
          mbusy[i] = 0;
          mpend[i] = 1;
          lo = r_iters[i*IW +: IW] + 8'd16;
          exp_data[maddr[i]] = 'h8000 + int'(lo);
        end
      end
    end
    if (fb_we) begin
      a = int'(fb_addr);
      found = 0;
      for (int i = 0; i < R; i++) begin
        if (mpend[i] && maddr[i] == a) begin
          found = 1;
          mpend[i] = 0;
        end
      end
      chk("wr_pending", found, 1);
      chk("wr_once", written[a], 0);
      chk("wr_data", fb_data, exp_data[a]);
      written[a] = 1;
      nwrites++;
      last_wr = cyc;
    end
    for (int i = 0; i < R; i++) begin
      if (r_start[i]) begin
        a = int'(r_y[i*YB +: YB]) * (1 << XB) + int'(r_x[i*XB +: XB]);
        chk("redisp", mbusy[i] | mpend[i], 0);
        chk("disp_addr", a, next_disp);
        next_disp++;
        mbusy[i] = 1;
        maddr[i] = a;
        rem[i] = auto_mode ? lat[i] : 0;
      end
    end
    if (frame_done) begin
      nfd++;
      fd_cyc = cyc;
    end
    r_done = '0;
    for (int i = 0; i < R; i++) begin
      if (rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) begin
          r_done[i] = 1'b1;
          r_iters[i*IW +: IW] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic run_frame(input int go_mid);
    int n;
    frame_clear();
    auto_mode = 1;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_on", busy, 1);
    n = 0;
    while (nfd == 0 && n < 4000) begin
      go = (n == go_mid);
      tick();
      n++;
    end
    go = 1'b0;
    chk("frame_done_seen", nfd, 1);
    chk("frame_writes", nwrites, NPIX);
    chk("fd_after_last_wr", fd_cyc - last_wr, 1);
    chk("busy_at_fd", busy, 1);
    tick();
    chk("fd_one_cycle", frame_done, 0);
    chk("busy_off", busy, 0);
    repeat (3) tick();
    chk("fd_count", nfd, 1);
  endtask

  task automatic burst(input int base);
    int n;
    r_done = '1;
    for (int i = 0; i < R; i++) r_iters[i*IW +: IW] = 8'(i + 1);
    tick();
    chk("burst_gap", fb_we, 0);
    for (int k = 0; k < R; k++) begin
      tick();
      chk("burst_we", fb_we, 1);
      chk("burst_addr", fb_addr, base + k);
      chk("burst_data", fb_data, 'h8011 + k);
    end
    n = 0;
    while (next_disp < base + 8 && n < 20) begin
      tick();
      n++;
    end
    chk("burst_refill", next_disp, base + 8);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    r_done = '0;
    r_iters = '0;
    auto_mode = 0;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    frame_clear();
    #3 rst_n = 1'b0;
    #1 chk("reset_outs", outs(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), 0);

    lat = '{9, 3, 5, 1};
    run_frame(-1);

    frame_clear();
    auto_mode = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (next_disp < 4 && n < 20) begin
      tick();
      n++;
    end
    chk("burst_disp", next_disp, 4);
    burst(0);
    burst(4);

    r_done = 4'b0001;
    r_iters[7:0] = 8'hF5;
    tick();
    chk("wrap_gap", fb_we, 0);
    r_done = 4'b0001;
    r_iters[7:0] = 8'h33;
    tick();
    chk("wrap_we", fb_we, 1);
    chk("wrap_addr", fb_addr, 8);
    chk("wrap_data", fb_data, 16'h8005);
    tick();
    chk("pend_dup_ignored", fb_we, 0);

    abort = 1'b1;
    go = 1'b1;
    tick();
    abort = 1'b0;
    go = 1'b0;
    chk("abort_outs", outs(), 0);
    r_done = '1;
    tick();
    chk("stray_idle_we", fb_we, 0);
    tick();
    chk("stray_idle_we2", fb_we, 0);
    chk("stray_busy", busy, 0);

    for (int i = 0; i < R; i++) lat[i] = int'($urandom_range(1, 12));
    run_frame(20);

    frame_clear();
    auto_mode = 1;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (40) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", outs(), 0);
    model_clear();
    r_done = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    for (int i = 0; i < R; i++) lat[i] = int'($urandom_range(1, 12));
    run_frame(-1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
